// File: rtl/dma_pkg.sv
// Shared DMA datapath definitions: skid_buffer default width and level-width helper.
package dma_pkg;

    localparam int unsigned SKID_DATA_W_DEF = 32;

    // Bits needed to hold a count in 0..n inclusive.
    function automatic int unsigned clog2_p1(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// One-entry skid buffer: combinational pass-through while empty, holds one word
// when downstream stalls so upstream ready comes straight from a register.
module skid_buffer
    import dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SKID_DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data
);

    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;

    // Capture only when a word is accepted while downstream is stalled.
    always_ff @(posedge clk) begin
        if (areset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (i_s_valid && !hold_valid && !i_m_ready) begin
            hold_valid <= 1'b1;
            hold_data  <= i_s_data;
        end else if (hold_valid && i_m_ready) begin
            hold_valid <= 1'b0;
        end
    end

    assign o_s_ready = ~hold_valid;
    assign o_m_valid = hold_valid | i_s_valid;
    assign o_m_data  = hold_valid ? hold_data : i_s_data;

endmodule

// File: rtl/sync_fifo_lvl.sv
// Synchronous valid/ready FIFO of arbitrary depth with occupancy level, almost
// flags, synchronous flush and optional skid stages on either side.
module sync_fifo_lvl
    import dma_pkg::*;
#(
    parameter  int unsigned FIFO_S_REG = 1,
    parameter  int unsigned FIFO_M_REG = 1,
    parameter  int unsigned FIFO_W     = 32,
    parameter  int unsigned FIFO_D     = 6,
    parameter  int unsigned AF_THRESH  = 4,
    parameter  int unsigned AE_THRESH  = 1,
    localparam int unsigned LVL_BW     = clog2_p1(FIFO_D)
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              i_flush,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [FIFO_W-1:0] i_s_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [FIFO_W-1:0] o_m_data,
    output logic [LVL_BW-1:0] o_level,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_almost_full,
    output logic              o_almost_empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_D);

    logic              skid_rst;
    logic              s_valid_g;
    logic              s_ready_raw;
    logic              m_ready_g;
    logic              m_valid_raw;
    logic              core_w_valid;
    logic              core_w_ready;
    logic [FIFO_W-1:0] core_w_data;
    logic              core_r_valid;
    logic              core_r_ready;
    logic [FIFO_W-1:0] core_r_data;
    logic              wr_en;
    logic              rd_en;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_BW-1:0] count;
    logic [FIFO_W-1:0] mem [FIFO_D];

    // Flush blocks every handshake in its cycle and empties the skid stages at the edge.
    assign skid_rst  = areset | i_flush;
    assign s_valid_g = i_s_valid & ~i_flush;
    assign m_ready_g = i_m_ready & ~i_flush;
    assign o_s_ready = s_ready_raw & ~i_flush;
    assign o_m_valid = m_valid_raw & ~i_flush;

    generate
        if (FIFO_S_REG != 0) begin : g_s_skid
            skid_buffer #(.DATA_WIDTH(FIFO_W)) u0_skid_buffer (
                .clk       (clk),
                .areset    (skid_rst),
                .i_s_valid (s_valid_g),
                .o_s_ready (s_ready_raw),
                .i_s_data  (i_s_data),
                .o_m_valid (core_w_valid),
                .i_m_ready (core_w_ready),
                .o_m_data  (core_w_data)
            );
        end else begin : g_s_direct
            assign core_w_valid = s_valid_g;
            assign s_ready_raw  = core_w_ready;
            assign core_w_data  = i_s_data;
        end

        if (FIFO_M_REG != 0) begin : g_m_skid
            skid_buffer #(.DATA_WIDTH(FIFO_W)) u1_skid_buffer (
                .clk       (clk),
                .areset    (skid_rst),
                .i_s_valid (core_r_valid),
                .o_s_ready (core_r_ready),
                .i_s_data  (core_r_data),
                .o_m_valid (m_valid_raw),
                .i_m_ready (m_ready_g),
                .o_m_data  (o_m_data)
            );
        end else begin : g_m_direct
            assign m_valid_raw  = core_r_valid;
            assign core_r_ready = m_ready_g;
            assign o_m_data     = core_r_data;
        end
    endgenerate

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign core_w_ready = ~o_full;
    assign core_r_valid = ~o_empty;
    assign core_r_data  = mem[rd_ptr];
    assign wr_en        = core_w_valid & core_w_ready & ~i_flush;
    assign rd_en        = core_r_valid & core_r_ready & ~i_flush;

    always_ff @(posedge clk) begin
        if (areset || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + LVL_BW'(1);
                2'b01:   count <= count - LVL_BW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage survives a flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (areset) begin
            for (int unsigned i = 0; i < FIFO_D; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= core_w_data;
        end
    end

    assign o_level        = count;
    assign o_empty        = (count == '0);
    assign o_full         = (count == LVL_BW'(FIFO_D));
    assign o_almost_full  = (count >= LVL_BW'(AF_THRESH));
    assign o_almost_empty = (count <= LVL_BW'(AE_THRESH));

    a_count_bounds: assert property (@(posedge clk) disable iff (areset)
        (count <= LVL_BW'(FIFO_D)) && !(rd_en && o_empty) && !(wr_en && o_full))
        else $error("sync_fifo_lvl count out of range");

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Bench for sync_fifo_lvl: thirteen configurations checked every cycle against a
// queue-based occupancy model, plus directed fill/stream/flush/reset scenarios.
module tb_sync_fifo_lvl;

    localparam int NI    = 13;
    localparam int K_DEF = 0;   // default params, both skids
    localparam int K_D5  = 5;   // FIFO_D=5, no skids

    function automatic int unsigned d_of(input int k);
        if (k == 0) return 6;
        case ((k - 1) / 4)
            0:       return 2;
            1:       return 5;
            default: return 8;
        endcase
    endfunction
    function automatic int unsigned s_of(input int k);
        return (k == 0) ? 1 : (((k - 1) % 4) / 2);
    endfunction
    function automatic int unsigned m_of(input int k);
        return (k == 0) ? 1 : ((k - 1) % 2);
    endfunction
    function automatic int unsigned af_of(input int k);
        return (k == 0) ? 4 : d_of(k) - 1;
    endfunction
    function automatic int unsigned ae_of(input int k);
        return (k < 0) ? 0 : 1;
    endfunction

    logic        clk = 1'b0;
    logic        areset [NI];
    logic        flush  [NI];
    logic        s_valid[NI];
    logic        s_ready[NI];
    logic [31:0] s_data [NI];
    logic        m_valid[NI];
    logic        m_ready[NI];
    logic [31:0] m_data [NI];
    logic [7:0]  level  [NI];
    logic        empty  [NI];
    logic        full   [NI];
    logic        afull  [NI];
    logic        aempty [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned LB = $clog2(d_of(g) + 1);
        logic [LB-1:0] lvl;
        sync_fifo_lvl #(
            .FIFO_S_REG (s_of(g)),
            .FIFO_M_REG (m_of(g)),
            .FIFO_W     (32),
            .FIFO_D     (d_of(g)),
            .AF_THRESH  (af_of(g)),
            .AE_THRESH  (ae_of(g))
        ) u_dut (
            .clk            (clk),
            .areset         (areset[g]),
            .i_flush        (flush[g]),
            .i_s_valid      (s_valid[g]),
            .o_s_ready      (s_ready[g]),
            .i_s_data       (s_data[g]),
            .o_m_valid      (m_valid[g]),
            .i_m_ready      (m_ready[g]),
            .o_m_data       (m_data[g]),
            .o_level        (lvl),
            .o_empty        (empty[g]),
            .o_full         (full[g]),
            .o_almost_full  (afull[g]),
            .o_almost_empty (aempty[g])
        );
        assign level[g] = 8'(lvl);
    end

    // Model: every word in flight in arrival order, plus how many sit in each skid stage.
    logic [31:0] mq [NI][$];
    int ns [NI];
    int nm [NI];
    int out_cnt [NI];

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        for (int k = 0; k < NI; k++) begin
            ns[k] = 0; nm[k] = 0; out_cnt[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            int lvl, d;
            bit sr, mv, sf, mf, cw, cr;
            if (areset[k] || flush[k]) begin
                mq[k].delete();
                ns[k] = 0;
                nm[k] = 0;
            end else begin
                d   = int'(d_of(k));
                lvl = mq[k].size() - ns[k] - nm[k];
                sr  = (s_of(k) != 0) ? (ns[k] == 0) : (lvl < d);
                mv  = (nm[k] > 0) || (lvl > 0);
                sf  = s_valid[k] && sr;
                mf  = mv && m_ready[k];
                cw  = (s_of(k) != 0) ? (((ns[k] > 0) || s_valid[k]) && (lvl < d)) : sf;
                cr  = (m_of(k) != 0) ? ((lvl > 0) && (nm[k] == 0)) : mf;
                if (s_of(k) != 0)
                    ns[k] = (ns[k] == 0) ? ((sf && !cw) ? 1 : 0) : (cw ? 0 : 1);
                if (m_of(k) != 0)
                    nm[k] = (nm[k] == 0) ? ((cr && !m_ready[k]) ? 1 : 0) : (m_ready[k] ? 0 : 1);
                if (sf) mq[k].push_back(s_data[k]);
                if (mf) begin
                    void'(mq[k].pop_front());
                    out_cnt[k] = out_cnt[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm_s, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst %0d at %0t: got 0x%0h expected 0x%0h", nm_s, k, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            int lvl, d;
            bit esr, emv;
            if (areset[k]) continue;
            d   = int'(d_of(k));
            lvl = mq[k].size() - ns[k] - nm[k];
            esr = !flush[k] && ((s_of(k) != 0) ? (ns[k] == 0) : (lvl < d));
            emv = !flush[k] && ((nm[k] > 0) || (lvl > 0));
            chk("s_ready", k, 32'(s_ready[k]), 32'(esr));
            chk("m_valid", k, 32'(m_valid[k]), 32'(emv));
            if (emv) chk("m_data", k, m_data[k], mq[k][0]);
            chk("level",   k, 32'(level[k]),  32'(lvl));
            chk("empty",   k, 32'(empty[k]),  32'(lvl == 0));
            chk("full",    k, 32'(full[k]),   32'(lvl == d));
            chk("afull",   k, 32'(afull[k]),  32'(lvl >= int'(af_of(k))));
            chk("aempty",  k, 32'(aempty[k]), 32'(lvl <= int'(ae_of(k))));
        end
    endtask

    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, got, sent, rcv, base_cnt, cyc;
        bit fire, done;
        bit fired [NI];
        for (int k = 0; k < NI; k++) begin
            areset[k] = 1'b1; flush[k] = 1'b0; s_valid[k] = 1'b0;
            s_data[k] = '0; m_ready[k] = 1'b0; fired[k] = 1'b0;
        end
        adv(); adv();
        for (int k = 0; k < NI; k++) areset[k] = 1'b0;

        // Reset state of the default instance.
        settle();
        chk("rst_s_ready", K_DEF, 32'(s_ready[K_DEF]), 32'd1);
        chk("rst_m_valid", K_DEF, 32'(m_valid[K_DEF]), 32'd0);
        chk("rst_level",   K_DEF, 32'(level[K_DEF]),   32'd0);
        chk("rst_empty",   K_DEF, 32'(empty[K_DEF]),   32'd1);
        chk("rst_full",    K_DEF, 32'(full[K_DEF]),    32'd0);
        chk("rst_aempty",  K_DEF, 32'(aempty[K_DEF]),  32'd1);
        chk("rst_afull",   K_DEF, 32'(afull[K_DEF]),   32'd0);
        adv();

        // Fill default instance with downstream stalled: skids hold one word each.
        w = 0;
        m_ready[K_DEF] = 1'b0; s_valid[K_DEF] = 1'b1; s_data[K_DEF] = 32'h11;
        for (int i = 0; i < 12; i++) begin
            settle();
            fire = s_valid[K_DEF] && s_ready[K_DEF];
            adv();
            if (fire) begin
                w++;
                if (w < 8) s_data[K_DEF] = 32'h11 + 32'(w);
                else s_valid[K_DEF] = 1'b0;
            end
        end
        settle();
        chk("fill_accepted", K_DEF, 32'(w), 32'd8);
        chk("fill_level",    K_DEF, 32'(level[K_DEF]),   32'd6);
        chk("fill_full",     K_DEF, 32'(full[K_DEF]),    32'd1);
        chk("fill_afull",    K_DEF, 32'(afull[K_DEF]),   32'd1);
        chk("fill_s_ready",  K_DEF, 32'(s_ready[K_DEF]), 32'd0);
        adv();
        got = 0;
        m_ready[K_DEF] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (m_valid[K_DEF] && m_ready[K_DEF]) begin
                chk("drain_data", K_DEF, m_data[K_DEF], 32'h11 + 32'(got));
                got++;
            end
            adv();
        end
        m_ready[K_DEF] = 1'b0;
        chk("drain_count", K_DEF, 32'(got), 32'd8);

        // Back-to-back stream through depth-5 core: level pinned at 1, pointers wrap.
        sent = 0; rcv = 0;
        m_ready[K_D5] = 1'b1; s_valid[K_D5] = 1'b1; s_data[K_D5] = 32'h1000;
        for (int i = 0; i < 25; i++) begin
            settle();
            if (i >= 1 && i <= 23) chk("stream_level", K_D5, 32'(level[K_D5]), 32'd1);
            if (m_valid[K_D5] && m_ready[K_D5]) begin
                chk("stream_data", K_D5, m_data[K_D5], 32'h1000 + 32'(rcv));
                rcv++;
            end
            fire = s_valid[K_D5] && s_ready[K_D5];
            adv();
            if (fire) begin
                sent++;
                if (sent < 23) s_data[K_D5] = 32'h1000 + 32'(sent);
                else s_valid[K_D5] = 1'b0;
            end
        end
        chk("stream_count", K_D5, 32'(rcv), 32'd23);

        // Fill to 3 then simultaneous push/pop for 10 cycles.
        sent = 0; rcv = 0;
        for (int i = 0; i < 20; i++) begin
            s_valid[K_D5] = (sent < 13);
            s_data[K_D5]  = 32'h2000 + 32'(sent);
            m_ready[K_D5] = (i >= 3);
            settle();
            if (i >= 3 && i <= 12) chk("pushpop_level", K_D5, 32'(level[K_D5]), 32'd3);
            if (m_valid[K_D5] && m_ready[K_D5]) begin
                chk("pushpop_data", K_D5, m_data[K_D5], 32'h2000 + 32'(rcv));
                rcv++;
            end
            fire = s_valid[K_D5] && s_ready[K_D5];
            adv();
            if (fire) sent++;
        end
        s_valid[K_D5] = 1'b0; m_ready[K_D5] = 1'b0;
        chk("pushpop_count", K_D5, 32'(rcv), 32'd13);

        // Fill to 5, flush with a pending word, that word must be the first out.
        for (int i = 0; i < 5; i++) begin
            s_valid[K_D5] = 1'b1; s_data[K_D5] = 32'h3000 + 32'(i);
            settle();
            adv();
        end
        s_valid[K_D5] = 1'b0;
        settle();
        chk("prefl_level", K_D5, 32'(level[K_D5]), 32'd5);
        adv();
        flush[K_D5] = 1'b1; s_valid[K_D5] = 1'b1; s_data[K_D5] = 32'hAA;
        settle();
        chk("fl_s_ready", K_D5, 32'(s_ready[K_D5]), 32'd0);
        chk("fl_m_valid", K_D5, 32'(m_valid[K_D5]), 32'd0);
        adv();
        flush[K_D5] = 1'b0;
        settle();
        chk("postfl_level",   K_D5, 32'(level[K_D5]),   32'd0);
        chk("postfl_empty",   K_D5, 32'(empty[K_D5]),   32'd1);
        chk("postfl_s_ready", K_D5, 32'(s_ready[K_D5]), 32'd1);
        adv();
        s_valid[K_D5] = 1'b0;
        settle();
        chk("postfl_m_valid", K_D5, 32'(m_valid[K_D5]), 32'd1);
        chk("postfl_m_data",  K_D5, m_data[K_D5],       32'hAA);
        adv();
        m_ready[K_D5] = 1'b1;
        settle();
        adv();
        m_ready[K_D5] = 1'b0;

        // Mid-stream reset of the default (both skids) instance.
        s_valid[K_DEF] = 1'b1; s_data[K_DEF] = 32'h5000; w = 0;
        for (int i = 0; i < 10; i++) begin
            m_ready[K_DEF] = (i % 3 == 0);
            settle();
            fire = s_valid[K_DEF] && s_ready[K_DEF];
            adv();
            if (fire) begin
                w++;
                s_data[K_DEF] = 32'h5000 + 32'(w);
            end
        end
        areset[K_DEF] = 1'b1;
        settle();
        adv();
        areset[K_DEF] = 1'b0; s_valid[K_DEF] = 1'b0; m_ready[K_DEF] = 1'b0;
        settle();
        chk("ar_m_valid", K_DEF, 32'(m_valid[K_DEF]), 32'd0);
        chk("ar_level",   K_DEF, 32'(level[K_DEF]),   32'd0);
        chk("ar_s_ready", K_DEF, 32'(s_ready[K_DEF]), 32'd1);
        adv();

        // Random 50% valid/ready on every configuration until each has moved 10k words.
        base_cnt = 0;
        for (int k = 1; k < NI; k++) out_cnt[k] = 0;
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < 60000) begin
            for (int k = 0; k < NI; k++) begin
                if (!s_valid[k] || fired[k]) begin
                    s_valid[k] = 1'($urandom_range(0, 1));
                    s_data[k]  = $urandom;
                end
                m_ready[k] = 1'($urandom_range(0, 1));
            end
            settle();
            for (int k = 0; k < NI; k++) fired[k] = s_valid[k] && s_ready[k];
            adv();
            cyc++;
            done = 1'b1;
            for (int k = 1; k < NI; k++) if (out_cnt[k] < 10000) done = 1'b0;
        end
        for (int k = 1; k < NI; k++)
            chk("rand_words_done", k, 32'(out_cnt[k] >= 10000), 32'd1);
        chk("rand_budget", base_cnt, 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
